// File: rtl/if_stage_params.sv
// Shared types and constants for the IF stage: ID->IF branch bus, IF->ID instruction bus,
// and the instruction SRAM request bundle.
package if_stage_params;

  localparam logic [31:0] RESET_PROGRAM_COUNT = 32'hBFC0_0000;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } IDToIFBranchBusData;

  typedef struct packed {
    logic        valid;
    logic [31:0] program_count;
    logic [31:0] instruction;
  } IFToIDInstructionBusData;

  typedef struct packed {
    logic        en;
    logic [31:0] addr;
  } InstructionSramRequest;

endpackage

// File: rtl/if_stage_fetch_unit_buffer.sv
// Holds the SRAM read word while ID back-pressures, since SRAM data is only valid for one
// cycle after its request.
module if_instruction_buffer (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_valid,
  input  logic        id_allow_in,
  input  logic [31:0] inst_sram_rdata,
  output logic [31:0] instruction
);

  logic        buffer_valid;
  logic [31:0] buffer_data;

  // Capture only on the first stalled cycle; later cycles see garbage on rdata.
  always_ff @(posedge clock) begin
    if (reset) begin
      buffer_valid <= 1'b0;
      buffer_data  <= '0;
    end else if (id_allow_in) begin
      buffer_valid <= 1'b0;
    end else if (if_valid && !buffer_valid) begin
      buffer_valid <= 1'b1;
      buffer_data  <= inst_sram_rdata;
    end
  end

  assign instruction = buffer_valid ? buffer_data : inst_sram_rdata;

endmodule

// File: rtl/if_stage_fetch_unit.sv
// Instruction-fetch stage: next-PC generation with MIPS delay-slot redirect and SRAM request.
// Optional macro IF_STALL_COUNTER_EN adds the if_stall_cycles back-pressure counter port.
module if_stage_fetch_unit
  import if_stage_params::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PROGRAM_COUNT
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    id_allow_in,
  input  IDToIFBranchBusData      branch_bus,
  output IFToIDInstructionBusData if_to_id_bus,
  output logic                    inst_sram_en,
  output logic [31:0]             inst_sram_addr,
`ifdef IF_STALL_COUNTER_EN
  output logic [31:0]             if_stall_cycles,
`endif
  input  logic [31:0]             inst_sram_rdata
);

  logic                  if_valid;
  logic [31:0]           if_pc;
  logic                  pending_valid;
  logic [31:0]           pending_target;
  logic                  if_ready_go;
  logic                  if_allow_in;
  logic                  redirect;
  logic [31:0]           redirect_target;
  logic [31:0]           next_pc;
  logic [31:0]           instruction;
  InstructionSramRequest sram_request;

  assign if_ready_go = 1'b1;
  assign if_allow_in = !if_valid || (if_ready_go && id_allow_in);

  // A redirect needs the delay slot already held in IF, hence the if_valid qualifier.
  always_comb begin
    redirect          = (branch_bus.taken || pending_valid) && if_valid;
    redirect_target   = branch_bus.taken ? branch_bus.target : pending_target;
    next_pc           = redirect ? redirect_target : if_pc + 32'd4;
    sram_request.en   = !reset && if_allow_in;
    sram_request.addr = reset ? RESET_PC : next_pc;
  end

  assign inst_sram_en   = sram_request.en;
  assign inst_sram_addr = sram_request.addr;

  always_ff @(posedge clock) begin
    if (reset) begin
      if_valid <= 1'b0;
      if_pc    <= RESET_PC - 32'd4;
    end else if (sram_request.en) begin
      if_valid <= 1'b1;
      if_pc    <= next_pc;
    end
  end

  // Taken with an empty IF means the delay slot is not fetched yet; remember the target.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending_valid  <= 1'b0;
      pending_target <= '0;
    end else if (branch_bus.taken && !if_valid) begin
      pending_valid  <= 1'b1;
      pending_target <= branch_bus.target;
    end else if (redirect && sram_request.en) begin
      pending_valid  <= 1'b0;
    end
  end

  if_instruction_buffer u_buffer (
    .clock           (clock),
    .reset           (reset),
    .if_valid        (if_valid),
    .id_allow_in     (id_allow_in),
    .inst_sram_rdata (inst_sram_rdata),
    .instruction     (instruction)
  );

  assign if_to_id_bus = '{valid: if_valid, program_count: if_pc, instruction: instruction};

`ifdef IF_STALL_COUNTER_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      if_stall_cycles <= '0;
    end else if (if_valid && !id_allow_in) begin
      if_stall_cycles <= if_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage_fetch_unit.sv
// Directed bench for if_stage_fetch_unit with a behavioural one-cycle-latency SRAM.
// Stall counter checks are compiled in when IF_STALL_COUNTER_EN is defined.
module tb_if_stage_fetch_unit;
  import if_stage_params::*;

  logic                    clock;
  logic                    reset;
  logic                    id_allow_in;
  IDToIFBranchBusData      branch_bus;
  IFToIDInstructionBusData if_to_id_bus;
  logic                    inst_sram_en;
  logic [31:0]             inst_sram_addr;
  logic [31:0]             inst_sram_rdata;
`ifdef IF_STALL_COUNTER_EN
  logic [31:0]             if_stall_cycles;
`endif

  int          errors = 0;
  int          checks = 0;
  logic [31:0] sram_salt = 32'h1234_5678;

  if_stage_fetch_unit dut (
    .clock           (clock),
    .reset           (reset),
    .id_allow_in     (id_allow_in),
    .branch_bus      (branch_bus),
    .if_to_id_bus    (if_to_id_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_addr  (inst_sram_addr),
`ifdef IF_STALL_COUNTER_EN
    .if_stall_cycles (if_stall_cycles),
`endif
    .inst_sram_rdata (inst_sram_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] word_at(input logic [31:0] addr);
    return (addr == 32'hBFC0_0004) ? 32'h2408_0001 : (addr ^ sram_salt);
  endfunction

  // SRAM returns garbage when not enabled so a missing hold buffer is visible.
  always @(posedge clock) begin
    if (inst_sram_en) inst_sram_rdata <= word_at(inst_sram_addr);
    else              inst_sram_rdata <= 32'hDEAD_BEEF;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    id_allow_in = 1'b1;
    branch_bus  = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    id_allow_in = 1'b1;
    branch_bus  = '0;
    tick();
    tick();
    checks++;
    if (inst_sram_en !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_en: got %b expected 0", inst_sram_en);
    end
    checks++;
    if (inst_sram_addr !== 32'hBFC0_0000) begin
      errors++; $display("[TB] FAIL reset_addr: got %h expected bfc00000", inst_sram_addr);
    end
    checks++;
    if (if_to_id_bus.valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_valid: got %b expected 0", if_to_id_bus.valid);
    end
`ifdef IF_STALL_COUNTER_EN
    checks++;
    if (if_stall_cycles !== 32'd0) begin
      errors++; $display("[TB] FAIL reset_stall_count: got %0d expected 0", if_stall_cycles);
    end
`endif
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    do_reset();
    checks++;
    if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'hBFC0_0000) begin
      errors++;
      $display("[TB] FAIL seq_first_req: got en=%b addr=%h expected en=1 addr=bfc00000",
               inst_sram_en, inst_sram_addr);
    end
    checks++;
    if (if_to_id_bus.valid !== 1'b0) begin
      errors++; $display("[TB] FAIL seq_first_valid: got %b expected 0", if_to_id_bus.valid);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      exp_pc = 32'hBFC0_0000 + 32'(4 * (i - 1));
      checks++;
      if (if_to_id_bus.valid !== 1'b1 || if_to_id_bus.program_count !== exp_pc) begin
        errors++;
        $display("[TB] FAIL seq_bus_pc[%0d]: got valid=%b pc=%h expected valid=1 pc=%h",
                 i, if_to_id_bus.valid, if_to_id_bus.program_count, exp_pc);
      end
      checks++;
      if (if_to_id_bus.instruction !== word_at(exp_pc)) begin
        errors++;
        $display("[TB] FAIL seq_bus_instr[%0d]: got %h expected %h",
                 i, if_to_id_bus.instruction, word_at(exp_pc));
      end
      checks++;
      if (inst_sram_addr !== exp_pc + 32'd4) begin
        errors++;
        $display("[TB] FAIL seq_addr[%0d]: got %h expected %h", i, inst_sram_addr, exp_pc + 32'd4);
      end
    end
  endtask

  task automatic test_branch_taken();
    do_reset();
    tick();
    tick();
    branch_bus = '{taken: 1'b1, target: 32'h8000_0100};
    #1;
    checks++;
    if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h8000_0100) begin
      errors++;
      $display("[TB] FAIL branch_redirect: got en=%b addr=%h expected en=1 addr=80000100",
               inst_sram_en, inst_sram_addr);
    end
    checks++;
    if (if_to_id_bus.program_count !== 32'hBFC0_0004 || if_to_id_bus.valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL branch_delay_slot: got valid=%b pc=%h expected valid=1 pc=bfc00004",
               if_to_id_bus.valid, if_to_id_bus.program_count);
    end
    tick();
    branch_bus = '0;
    #1;
    checks++;
    if (if_to_id_bus.valid !== 1'b1 || if_to_id_bus.program_count !== 32'h8000_0100) begin
      errors++;
      $display("[TB] FAIL branch_target_pc: got valid=%b pc=%h expected valid=1 pc=80000100",
               if_to_id_bus.valid, if_to_id_bus.program_count);
    end
    checks++;
    if (if_to_id_bus.instruction !== word_at(32'h8000_0100)) begin
      errors++;
      $display("[TB] FAIL branch_target_instr: got %h expected %h",
               if_to_id_bus.instruction, word_at(32'h8000_0100));
    end
    checks++;
    if (inst_sram_addr !== 32'h8000_0104) begin
      errors++; $display("[TB] FAIL branch_after: got %h expected 80000104", inst_sram_addr);
    end
  endtask

  task automatic test_delay_slot_pending();
    do_reset();
    branch_bus = '{taken: 1'b1, target: 32'h8000_0200};
    #1;
    checks++;
    if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'hBFC0_0000) begin
      errors++;
      $display("[TB] FAIL pend_slot_addr: got en=%b addr=%h expected en=1 addr=bfc00000",
               inst_sram_en, inst_sram_addr);
    end
    tick();
    branch_bus = '0;
    #1;
    checks++;
    if (inst_sram_addr !== 32'h8000_0200) begin
      errors++; $display("[TB] FAIL pend_redirect: got %h expected 80000200", inst_sram_addr);
    end
    checks++;
    if (if_to_id_bus.program_count !== 32'hBFC0_0000 || if_to_id_bus.valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pend_slot_bus: got valid=%b pc=%h expected valid=1 pc=bfc00000",
               if_to_id_bus.valid, if_to_id_bus.program_count);
    end
    tick();
    checks++;
    if (if_to_id_bus.program_count !== 32'h8000_0200) begin
      errors++;
      $display("[TB] FAIL pend_target_bus: got %h expected 80000200", if_to_id_bus.program_count);
    end
    checks++;
    if (inst_sram_addr !== 32'h8000_0204) begin
      errors++; $display("[TB] FAIL pend_cleared: got %h expected 80000204", inst_sram_addr);
    end
    tick();
    checks++;
    if (inst_sram_addr !== 32'h8000_0208) begin
      errors++; $display("[TB] FAIL pend_seq: got %h expected 80000208", inst_sram_addr);
    end
  endtask

  task automatic test_back_pressure();
    do_reset();
    tick();
    tick();
    id_allow_in = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (inst_sram_en !== 1'b0) begin
        errors++; $display("[TB] FAIL stall_en[%0d]: got %b expected 0", k, inst_sram_en);
      end
      checks++;
      if (if_to_id_bus.valid !== 1'b1 || if_to_id_bus.program_count !== 32'hBFC0_0004 ||
          if_to_id_bus.instruction !== 32'h2408_0001) begin
        errors++;
        $display("[TB] FAIL stall_hold[%0d]: got v=%b pc=%h instr=%h expected v=1 pc=bfc00004 instr=24080001",
                 k, if_to_id_bus.valid, if_to_id_bus.program_count, if_to_id_bus.instruction);
      end
      tick();
    end
    id_allow_in = 1'b1;
    #1;
    checks++;
    if (if_to_id_bus.program_count !== 32'hBFC0_0004 ||
        if_to_id_bus.instruction !== 32'h2408_0001) begin
      errors++;
      $display("[TB] FAIL stall_release_word: got pc=%h instr=%h expected pc=bfc00004 instr=24080001",
               if_to_id_bus.program_count, if_to_id_bus.instruction);
    end
    checks++;
    if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'hBFC0_0008) begin
      errors++;
      $display("[TB] FAIL stall_resume: got en=%b addr=%h expected en=1 addr=bfc00008",
               inst_sram_en, inst_sram_addr);
    end
`ifdef IF_STALL_COUNTER_EN
    checks++;
    if (if_stall_cycles !== 32'd3) begin
      errors++; $display("[TB] FAIL stall_count: got %0d expected 3", if_stall_cycles);
    end
`endif
    tick();
    checks++;
    if (if_to_id_bus.program_count !== 32'hBFC0_0008 ||
        if_to_id_bus.instruction !== word_at(32'hBFC0_0008)) begin
      errors++;
      $display("[TB] FAIL stall_next: got pc=%h instr=%h expected pc=bfc00008 instr=%h",
               if_to_id_bus.program_count, if_to_id_bus.instruction, word_at(32'hBFC0_0008));
    end
  endtask

  task automatic test_reset_mid_stream();
    do_reset();
    branch_bus = '{taken: 1'b1, target: 32'h8000_0300};
    tick();
    branch_bus  = '0;
    id_allow_in = 1'b0;
    #1;
    checks++;
    if (inst_sram_en !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_stall_en: got %b expected 0", inst_sram_en);
    end
    tick();
    reset     = 1'b1;
    sram_salt = 32'h0F0F_F0F0;
    #1;
    checks++;
    if (inst_sram_en !== 1'b0 || inst_sram_addr !== 32'hBFC0_0000) begin
      errors++;
      $display("[TB] FAIL mid_reset_req: got en=%b addr=%h expected en=0 addr=bfc00000",
               inst_sram_en, inst_sram_addr);
    end
    tick();
    checks++;
    if (if_to_id_bus.valid !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_reset_valid: got %b expected 0", if_to_id_bus.valid);
    end
    reset       = 1'b0;
    id_allow_in = 1'b1;
    #1;
    checks++;
    if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'hBFC0_0000) begin
      errors++;
      $display("[TB] FAIL mid_restart: got en=%b addr=%h expected en=1 addr=bfc00000",
               inst_sram_en, inst_sram_addr);
    end
    tick();
    checks++;
    if (if_to_id_bus.program_count !== 32'hBFC0_0000 ||
        if_to_id_bus.instruction !== word_at(32'hBFC0_0000)) begin
      errors++;
      $display("[TB] FAIL mid_first_word: got pc=%h instr=%h expected pc=bfc00000 instr=%h",
               if_to_id_bus.program_count, if_to_id_bus.instruction, word_at(32'hBFC0_0000));
    end
    checks++;
    if (inst_sram_addr !== 32'hBFC0_0004) begin
      errors++; $display("[TB] FAIL mid_no_stale_redirect: got %h expected bfc00004", inst_sram_addr);
    end
  endtask

  initial begin
    reset       = 1'b1;
    id_allow_in = 1'b1;
    branch_bus  = '0;
    test_reset();
    test_sequential();
    test_branch_taken();
    test_delay_slot_pending();
    test_back_pressure();
    test_reset_mid_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
